// File: rtl/ov5640_pkg.sv
// Shared types and constants for the OV5640 init sequencer.
package ov5640_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PWRUP,
        ST_FETCH,
        ST_LATCH,
        ST_REQ,
        ST_WAIT,
        ST_SDELAY,
        ST_NEXT,
        ST_DONE,
        ST_ERROR
    } state_t;

    // Writing SRST_BIT of this register soft-resets the sensor.
    localparam logic [15:0] SRST_REG = 16'h3008;
    localparam int          SRST_BIT = 7;

    // Converts a delay in microseconds to clock cycles. 64-bit math because
    // 20 ms at 50 MHz overflows 32 bits before the divide.
    function automatic longint unsigned us_to_clks(input longint unsigned delay_us,
                                                   input longint unsigned clk_hz);
        return (delay_us * clk_hz) / 64'd1_000_000;
    endfunction

endpackage

// File: rtl/ov5640_delay_timer.sv
// Down-counting delay timer: load sets the count, expired flags terminal count.
module ov5640_delay_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    // Load has priority; otherwise count down and hold at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/ov5640_init_sequencer.sv
// Walks the OV5640 init ROM and issues one SCCB write per entry, with
// power-up and soft-reset settle delays and bounded NACK retries.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  ST_IDLE   | after reset; leaves on start or the implicit reset start
//  ST_PWRUP  | power-up settle delay
//  ST_FETCH  | rom_addr = idx, ROM read in progress
//  ST_LATCH  | ROM word valid, capture into wr_reg_addr/wr_data
//  ST_REQ    | wr_valid high until wr_ready
//  ST_WAIT   | write accepted, waiting for wr_done
//  ST_SDELAY | settle delay after a soft-reset write
//  ST_NEXT   | advance idx or finish
//  ST_DONE   | all entries written
//  ST_ERROR  | retries exhausted on entry err_index
module ov5640_init_sequencer
    import ov5640_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 8,
    parameter int          DATA_WIDTH     = 24,
    parameter int          TABLE_LEN      = 252,
    parameter int unsigned CLK_FREQ_HZ    = 50_000_000,
    parameter int unsigned PWRUP_DELAY_US = 20_000,
    parameter int unsigned SRST_DELAY_US  = 5_000,
    parameter int          MAX_RETRY      = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_q,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic [15:0]           wr_reg_addr,
    output logic [7:0]            wr_data,
    input  logic                  wr_done,
    input  logic                  wr_nack,
    output logic                  init_busy,
    output logic                  init_done,
    output logic                  init_err,
    output logic [ADDR_WIDTH-1:0] err_index
);

    localparam longint unsigned PWRUP_CLKS = us_to_clks(64'(PWRUP_DELAY_US), 64'(CLK_FREQ_HZ));
    localparam longint unsigned SRST_CLKS  = us_to_clks(64'(SRST_DELAY_US), 64'(CLK_FREQ_HZ));
    localparam longint unsigned MAX_CLKS   = (PWRUP_CLKS > SRST_CLKS) ? PWRUP_CLKS : SRST_CLKS;
    localparam int              CNT_W      = (MAX_CLKS == 0) ? 1 : $clog2(MAX_CLKS + 1);
    localparam logic [CNT_W-1:0] PWRUP_LOAD = CNT_W'(PWRUP_CLKS);
    localparam logic [CNT_W-1:0] SRST_LOAD  = CNT_W'(SRST_CLKS);

    localparam int              RETRY_W     = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(TABLE_LEN - 1);

    state_t               state;
    state_t               state_nxt;
    logic [ADDR_WIDTH-1:0] idx;
    logic [RETRY_W-1:0]   retry_cnt;
    logic                 auto_pend;
    logic                 tmr_load;
    logic [CNT_W-1:0]     tmr_val;
    logic                 tmr_expired;
    logic                 run_start;
    logic                 is_srst;
    logic                 is_last;

    assign is_srst   = (wr_reg_addr == SRST_REG) && wr_data[SRST_BIT];
    assign is_last   = (idx == LAST_IDX);
    assign run_start = (state_nxt == ST_PWRUP) && (state != ST_PWRUP);

    ov5640_delay_timer #(
        .WIDTH (CNT_W)
    ) u_delay_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; the timer is loaded on entry to each delay state.
    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_val   = PWRUP_LOAD;
        case (state)
            ST_IDLE: begin
                if (start || auto_pend) begin
                    state_nxt = ST_PWRUP;
                    tmr_load  = 1'b1;
                end
            end
            ST_PWRUP:  if (tmr_expired) state_nxt = ST_FETCH;
            ST_FETCH:  state_nxt = ST_LATCH;
            ST_LATCH:  state_nxt = ST_REQ;
            ST_REQ:    if (wr_ready) state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (wr_done) begin
                    if (wr_nack) begin
                        state_nxt = (retry_cnt < RETRY_LIMIT) ? ST_REQ : ST_ERROR;
                    end else if (is_srst) begin
                        state_nxt = ST_SDELAY;
                        tmr_load  = 1'b1;
                        tmr_val   = SRST_LOAD;
                    end else begin
                        state_nxt = ST_NEXT;
                    end
                end
            end
            ST_SDELAY: if (tmr_expired) state_nxt = ST_NEXT;
            ST_NEXT:   state_nxt = is_last ? ST_DONE : ST_FETCH;
            ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_nxt = ST_PWRUP;
                    tmr_load  = 1'b1;
                end
            end
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Sequence datapath: entry index, retry count, captured entry and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx         <= '0;
            retry_cnt   <= '0;
            auto_pend   <= 1'b1;
            wr_reg_addr <= '0;
            wr_data     <= '0;
            init_done   <= 1'b0;
            init_err    <= 1'b0;
            err_index   <= '0;
        end else begin
            if (state == ST_IDLE) begin
                auto_pend <= 1'b0;
            end
            if (run_start) begin
                idx       <= '0;
                retry_cnt <= '0;
                init_done <= 1'b0;
                init_err  <= 1'b0;
                err_index <= '0;
            end
            if (state == ST_LATCH) begin
                wr_reg_addr <= rom_q[DATA_WIDTH-1 -: 16];
                wr_data     <= rom_q[7:0];
            end
            if ((state == ST_WAIT) && wr_done && wr_nack) begin
                if (retry_cnt < RETRY_LIMIT) begin
                    retry_cnt <= retry_cnt + 1'b1;
                end else begin
                    init_err  <= 1'b1;
                    err_index <= idx;
                end
            end
            if (state == ST_NEXT) begin
                if (is_last) begin
                    init_done <= 1'b1;
                end else begin
                    idx       <= idx + 1'b1;
                    retry_cnt <= '0;
                end
            end
        end
    end

    assign rom_addr  = idx;
    assign wr_valid  = (state == ST_REQ);
    assign init_busy = (state != ST_IDLE) && (state != ST_DONE) && (state != ST_ERROR);

endmodule

// File: tb/tb_ov5640_init_sequencer.sv
// Directed bench for ov5640_init_sequencer with a small ROM and an SCCB slave model.
`timescale 1ns/1ps
module tb_ov5640_init_sequencer;

    localparam logic [23:0] ROM_INIT [6] = '{24'h3103_11, 24'h3008_82, 24'h3008_42,
                                              24'h3017_ff, 24'h3018_ff, 24'h3034_1a};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rom_addr;
    logic [23:0] rom_q = '0;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_reg_addr;
    logic [7:0]  wr_data;
    logic        wr_done;
    logic        wr_nack;
    logic        init_busy;
    logic        init_done;
    logic        init_err;
    logic [7:0]  err_index;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // slave model state and write log
    int          bst;
    int          bcnt;
    logic [15:0] seen_addr;
    logic [7:0]  seen_data;
    int          seen_cyc;
    logic [15:0] cur_addr;
    logic [15:0] nack_addr = 16'h3017;
    int          nack_left = 0;
    int          proto_err = 0;
    logic [15:0] q_addr [$];
    logic [7:0]  q_data [$];
    int          q_req [$];
    int          q_done [$];

    ov5640_init_sequencer #(
        .ADDR_WIDTH     (8),
        .DATA_WIDTH     (24),
        .TABLE_LEN      (6),
        .CLK_FREQ_HZ    (1_000_000),
        .PWRUP_DELAY_US (10),
        .SRST_DELAY_US  (5),
        .MAX_RETRY      (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .rom_addr    (rom_addr),
        .rom_q       (rom_q),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_reg_addr (wr_reg_addr),
        .wr_data     (wr_data),
        .wr_done     (wr_done),
        .wr_nack     (wr_nack),
        .init_busy   (init_busy),
        .init_done   (init_done),
        .init_err    (init_err),
        .err_index   (err_index)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) rom_q <= (rom_addr < 8'd6) ? ROM_INIT[rom_addr[2:0]] : 24'h0;

    // SCCB slave: ready in the 2nd cycle of wr_valid, done 4 cycles after acceptance.
    initial begin
        wr_ready = 1'b0;
        wr_done  = 1'b0;
        wr_nack  = 1'b0;
        bst      = 0;
        bcnt     = 0;
        forever begin
            @(negedge clk);
            wr_ready = 1'b0;
            wr_done  = 1'b0;
            wr_nack  = 1'b0;
            if (!rst_n) begin
                bst  = 0;
                bcnt = 0;
            end else if (bst == 0) begin
                if (wr_valid) begin
                    bcnt++;
                    if (bcnt == 1) begin
                        seen_addr = wr_reg_addr;
                        seen_data = wr_data;
                        seen_cyc  = cyc;
                    end else begin
                        if (wr_reg_addr !== seen_addr || wr_data !== seen_data) proto_err++;
                        wr_ready = 1'b1;
                        q_addr.push_back(wr_reg_addr);
                        q_data.push_back(wr_data);
                        q_req.push_back(seen_cyc);
                        cur_addr = wr_reg_addr;
                        bst  = 1;
                        bcnt = 0;
                    end
                end
            end else begin
                if (wr_valid) proto_err++;
                bcnt++;
                if (bcnt == 4) begin
                    wr_done = 1'b1;
                    if (cur_addr == nack_addr && nack_left > 0) begin
                        wr_nack = 1'b1;
                        nack_left--;
                    end
                    q_done.push_back(cyc);
                    bst  = 0;
                    bcnt = 0;
                end
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic clear_log();
        q_addr.delete();
        q_data.delete();
        q_req.delete();
        q_done.delete();
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({wr_valid, init_busy, init_done, init_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got valid/busy/done/err=%b required 0000",
                     {wr_valid, init_busy, init_done, init_err});
        end
        checks++;
        if ({rom_addr, err_index, wr_reg_addr, wr_data} !== 40'h0) begin
            errors++;
            $display("FAIL reset_buses: got rom_addr=%0h err_index=%0h reg=%0h data=%0h required all 0",
                     rom_addr, err_index, wr_reg_addr, wr_data);
        end
    endtask

    task automatic test_all_ack();
        int c0;
        clear_log();
        nack_left = 0;
        @(negedge clk);
        rst_n = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 1000 && init_done !== 1'b1; i++) @(negedge clk);
        checks++;
        if (init_done !== 1'b1 || init_busy !== 1'b0 || init_err !== 1'b0) begin
            errors++;
            $display("FAIL all_ack_flags: got done=%b busy=%b err=%b required 1 0 0",
                     init_done, init_busy, init_err);
        end
        checks++;
        if (q_addr.size() != 6) begin
            errors++;
            $display("FAIL all_ack_count: got %0d writes required 6", q_addr.size());
        end
        for (int i = 0; i < 6; i++) begin
            if (i < q_addr.size()) begin
                checks++;
                if ({q_addr[i], q_data[i]} !== ROM_INIT[i]) begin
                    errors++;
                    $display("FAIL all_ack_order[%0d]: got %h required %h", i,
                             {q_addr[i], q_data[i]}, ROM_INIT[i]);
                end
            end
        end
        if (q_req.size() > 0) begin
            checks++;
            if (q_req[0] - c0 < 13 || q_req[0] - c0 > 15) begin
                errors++;
                $display("FAIL pwrup_delay: got first request %0d clks after release required 13..15",
                         q_req[0] - c0);
            end
        end
        checks++;
        if (proto_err != 0) begin
            errors++;
            $display("FAIL all_ack_protocol: got %0d violations required 0", proto_err);
        end
    endtask

    task automatic test_srst_gap();
        int g;
        clear_log();
        pulse_start();
        for (int i = 0; i < 1000 && init_done !== 1'b1; i++) @(negedge clk);
        checks++;
        if (init_done !== 1'b1 || q_req.size() != 6 || q_done.size() != 6) begin
            errors++;
            $display("FAIL srst_run: got done=%b reqs=%0d dones=%0d required 1 6 6",
                     init_done, q_req.size(), q_done.size());
        end else begin
            g = q_req[1] - q_done[0];
            checks++;
            if (g != 4) begin
                errors++;
                $display("FAIL gap_entry0: got %0d clks required 4", g);
            end
            g = q_req[2] - q_done[1];
            checks++;
            if (g < 9 || g > 10) begin
                errors++;
                $display("FAIL gap_srst_82: got %0d clks required 9..10", g);
            end
            g = q_req[3] - q_done[2];
            checks++;
            if (g != 4) begin
                errors++;
                $display("FAIL gap_no_srst_42: got %0d clks required 4", g);
            end
        end
    endtask

    task automatic test_nack_retry();
        int exp_idx [8] = '{0, 1, 2, 3, 3, 3, 4, 5};
        clear_log();
        nack_left = 2;
        pulse_start();
        for (int i = 0; i < 1000 && init_done !== 1'b1; i++) @(negedge clk);
        checks++;
        if (init_done !== 1'b1 || init_err !== 1'b0) begin
            errors++;
            $display("FAIL retry_flags: got done=%b err=%b required 1 0", init_done, init_err);
        end
        checks++;
        if (q_addr.size() != 8) begin
            errors++;
            $display("FAIL retry_count: got %0d writes required 8", q_addr.size());
        end
        for (int i = 0; i < 8; i++) begin
            if (i < q_addr.size()) begin
                checks++;
                if ({q_addr[i], q_data[i]} !== ROM_INIT[exp_idx[i]]) begin
                    errors++;
                    $display("FAIL retry_order[%0d]: got %h required %h", i,
                             {q_addr[i], q_data[i]}, ROM_INIT[exp_idx[i]]);
                end
            end
        end
    endtask

    task automatic test_nack_abort();
        int n;
        int exp_idx [7] = '{0, 1, 2, 3, 3, 3, 3};
        clear_log();
        nack_left = 4;
        pulse_start();
        for (int i = 0; i < 1000 && init_err !== 1'b1; i++) @(negedge clk);
        checks++;
        if (init_err !== 1'b1 || err_index !== 8'd3 || init_done !== 1'b0 || init_busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_flags: got err=%b idx=%0d done=%b busy=%b required 1 3 0 0",
                     init_err, err_index, init_done, init_busy);
        end
        n = q_addr.size();
        repeat (50) @(negedge clk);
        checks++;
        if (q_addr.size() != 7 || n != 7) begin
            errors++;
            $display("FAIL abort_count: got %0d then %0d writes required 7", n, q_addr.size());
        end
        for (int i = 0; i < 7; i++) begin
            if (i < q_addr.size()) begin
                checks++;
                if ({q_addr[i], q_data[i]} !== ROM_INIT[exp_idx[i]]) begin
                    errors++;
                    $display("FAIL abort_order[%0d]: got %h required %h", i,
                             {q_addr[i], q_data[i]}, ROM_INIT[exp_idx[i]]);
                end
            end
        end
    endtask

    task automatic test_start_handling();
        clear_log();
        nack_left = 0;
        pulse_start();
        checks++;
        if (init_err !== 1'b0 || err_index !== 8'd0 || init_busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_clear: got err=%b idx=%0d busy=%b required 0 0 1",
                     init_err, err_index, init_busy);
        end
        for (int i = 0; i < 1000 && q_addr.size() < 3; i++) @(negedge clk);
        pulse_start();
        for (int i = 0; i < 1000 && init_done !== 1'b1; i++) @(negedge clk);
        checks++;
        if (init_done !== 1'b1 || q_addr.size() != 6) begin
            errors++;
            $display("FAIL busy_start_ignored: got done=%b writes=%0d required 1 6",
                     init_done, q_addr.size());
        end
        for (int i = 0; i < 6; i++) begin
            if (i < q_addr.size()) begin
                checks++;
                if ({q_addr[i], q_data[i]} !== ROM_INIT[i]) begin
                    errors++;
                    $display("FAIL restart_order[%0d]: got %h required %h", i,
                             {q_addr[i], q_data[i]}, ROM_INIT[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int c0;
        clear_log();
        pulse_start();
        for (int i = 0; i < 1000 && q_addr.size() < 3; i++) @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (init_busy !== 1'b1 || wr_reg_addr !== 16'h3008 || wr_data !== 8'h42) begin
            errors++;
            $display("FAIL mid_before: got busy=%b reg=%h data=%h required 1 3008 42",
                     init_busy, wr_reg_addr, wr_data);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({wr_valid, init_busy, init_done, init_err} !== 4'b0000 ||
            {rom_addr, err_index, wr_reg_addr, wr_data} !== 40'h0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got valid/busy/done/err=%b rom=%0h reg=%h data=%h required all 0",
                     {wr_valid, init_busy, init_done, init_err}, rom_addr, wr_reg_addr, wr_data);
        end
        repeat (2) @(negedge clk);
        clear_log();
        rst_n = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 1000 && init_done !== 1'b1; i++) @(negedge clk);
        checks++;
        if (init_done !== 1'b1 || q_addr.size() != 6) begin
            errors++;
            $display("FAIL mid_rerun: got done=%b writes=%0d required 1 6", init_done, q_addr.size());
        end
        for (int i = 0; i < 6; i++) begin
            if (i < q_addr.size()) begin
                checks++;
                if ({q_addr[i], q_data[i]} !== ROM_INIT[i]) begin
                    errors++;
                    $display("FAIL mid_rerun_order[%0d]: got %h required %h", i,
                             {q_addr[i], q_data[i]}, ROM_INIT[i]);
                end
            end
        end
        if (q_req.size() > 0) begin
            checks++;
            if (q_req[0] - c0 < 13 || q_req[0] - c0 > 15) begin
                errors++;
                $display("FAIL mid_pwrup_delay: got %0d clks required 13..15", q_req[0] - c0);
            end
        end
        checks++;
        if (proto_err != 0) begin
            errors++;
            $display("FAIL final_protocol: got %0d violations required 0", proto_err);
        end
    endtask

    initial begin
        test_reset();
        test_all_ack();
        test_srst_gap();
        test_nack_retry();
        test_nack_abort();
        test_start_handling();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
